flippy_game_controller: RTL and testbench



---
 rtl/flippy_game_controller.sv | 211 +++++++++++++++++++++
 tb/tb_flippy_game_controller.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flippy_game_controller.sv
// flippy_game_controller: sequencer for the falling-byte game.
// Drives per-column resets with staggered release, a level-dependent
// fall-rate strobe, a saturating score and a lives counter.
module flippy_game_controller #(
  parameter int NUM_COLUMNS    = 3,
  parameter int SCORE_WIDTH    = 8,
  parameter int LIVES          = 3,
  parameter int BASE_PERIOD    = 25000000,
  parameter int PERIOD_STEP    = 2500000,
  parameter int MIN_PERIOD     = 5000000,
  parameter int LEVEL_UP_SCORE = 8,
  parameter int SPAWN_GAP      = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NUM_COLUMNS-1:0] correct,
  input  logic [NUM_COLUMNS-1:0] game_over,
  output logic [NUM_COLUMNS-1:0] column_reset,
  output logic                   fall_tick,
  output logic [SCORE_WIDTH-1:0] score,
  output logic [3:0]             lives,
  output logic [3:0]             level,
  output logic                   playing,
  output logic                   ended
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SPAWN = 2'd1;
  localparam logic [1:0] ST_PLAY  = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  localparam int                     LVL_SHIFT  = $clog2(LEVEL_UP_SCORE);
  localparam logic [SCORE_WIDTH-1:0] SCORE_MAX  = '1;
  localparam logic [3:0]             LIVES_INIT = 4'(LIVES);
  localparam logic [NUM_COLUMNS-1:0] ALL_COLS   = '1;
  localparam logic [NUM_COLUMNS-1:0] COL0_ONLY  = NUM_COLUMNS'(1);
  localparam logic [39:0]            BASE_W     = 40'(BASE_PERIOD);
  localparam logic [39:0]            STEP_W     = 40'(PERIOD_STEP);
  localparam logic [39:0]            MIN_W      = 40'(MIN_PERIOD);

  // Number of set bits in a column vector (NUM_COLUMNS <= 8 fits in 4 bits).
  function automatic logic [3:0] popcount(input logic [NUM_COLUMNS-1:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < NUM_COLUMNS; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

  logic [1:0]             state_q, state_d;
  logic [NUM_COLUMNS-1:0] released_q, released_d;
  logic [SCORE_WIDTH-1:0] score_q, score_d;
  logic [3:0]             lives_q, lives_d;
  logic [3:0]             level_q, level_d;
  logic [31:0]            tick_cnt_q, tick_cnt_d;
  logic [31:0]            spawn_cnt_q, spawn_cnt_d;
  logic [NUM_COLUMNS-1:0] column_reset_q, column_reset_d;
  logic                   fall_tick_q, fall_tick_d;
  logic                   playing_q, playing_d;
  logic                   ended_q, ended_d;

  logic [39:0]            step_total_s;
  logic [31:0]            period_s;
  logic                   tick_due_s;
  logic [NUM_COLUMNS-1:0] hit_s, miss_s;
  logic [SCORE_WIDTH+3:0] score_sum_s;
  logic [3:0]             miss_n_s;
  logic [SCORE_WIDTH-1:0] level_raw_s;

  // Fall period for the current level, computed wide so large steps clamp instead of wrapping.
  always_comb begin
    step_total_s = 40'(level_q) * STEP_W;
    if (BASE_W >= step_total_s + MIN_W) begin
      period_s = 32'(BASE_W - step_total_s);
    end else begin
      period_s = 32'(MIN_W);
    end
    tick_due_s = (tick_cnt_q >= period_s - 32'd1);
  end

  // Next-state logic: FSM, tick counter, column release, score, lives and level.
  always_comb begin
    state_d        = state_q;
    released_d     = released_q;
    score_d        = score_q;
    lives_d        = lives_q;
    tick_cnt_d     = tick_cnt_q;
    spawn_cnt_d    = spawn_cnt_q;
    column_reset_d = ALL_COLS;
    fall_tick_d    = 1'b0;
    hit_s          = correct & released_q;
    miss_s         = game_over & released_q & ~correct;
    score_sum_s    = {4'd0, score_q} + {{SCORE_WIDTH{1'b0}}, popcount(hit_s)};
    miss_n_s       = popcount(miss_s);
    level_raw_s    = score_q >> LVL_SHIFT;
    if (32'(level_raw_s) > 32'd15) begin
      level_d = 4'd15;
    end else begin
      level_d = 4'(level_raw_s);
    end

    case (state_q)
      ST_IDLE, ST_OVER: begin
        tick_cnt_d  = 32'd0;
        spawn_cnt_d = 32'd0;
        released_d  = '0;
        if (start) begin
          state_d        = ST_SPAWN;
          score_d        = '0;
          lives_d        = LIVES_INIT;
          level_d        = 4'd0;
          released_d     = COL0_ONLY;
          column_reset_d = ~COL0_ONLY;
        end else begin
          column_reset_d = ALL_COLS;
        end
      end
      ST_SPAWN, ST_PLAY: begin
        if (tick_due_s) begin
          tick_cnt_d  = 32'd0;
          fall_tick_d = 1'b1;
          if (state_q == ST_SPAWN) begin
            spawn_cnt_d = spawn_cnt_q + 32'd1;
          end else begin
            spawn_cnt_d = spawn_cnt_q;
          end
        end else begin
          tick_cnt_d = tick_cnt_q + 32'd1;
        end
        // Column k is released once k*SPAWN_GAP ticks have elapsed since entry.
        for (int k = 0; k < NUM_COLUMNS; k++) begin
          if (32'(k * SPAWN_GAP) <= spawn_cnt_d) begin
            released_d[k] = 1'b1;
          end else begin
            released_d[k] = released_q[k];
          end
        end
        if (score_sum_s > {4'd0, SCORE_MAX}) begin
          score_d = SCORE_MAX;
        end else begin
          score_d = score_sum_s[SCORE_WIDTH-1:0];
        end
        if (miss_n_s >= lives_q) begin
          lives_d = 4'd0;
        end else begin
          lives_d = lives_q - miss_n_s;
        end
        if (released_d == ALL_COLS) begin
          state_d = ST_PLAY;
        end else begin
          state_d = ST_SPAWN;
        end
        column_reset_d = ~released_d | hit_s | miss_s;
        if (lives_d == 4'd0) begin
          state_d        = ST_OVER;
          column_reset_d = ALL_COLS;
          fall_tick_d    = 1'b0;
          tick_cnt_d     = 32'd0;
        end else begin
          state_d = state_d;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    playing_d = (state_d == ST_SPAWN) || (state_d == ST_PLAY);
    ended_d   = (state_d == ST_OVER);
  end

  // State and registered outputs, synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      released_q     <= '0;
      score_q        <= '0;
      lives_q        <= LIVES_INIT;
      level_q        <= 4'd0;
      tick_cnt_q     <= 32'd0;
      spawn_cnt_q    <= 32'd0;
      column_reset_q <= ALL_COLS;
      fall_tick_q    <= 1'b0;
      playing_q      <= 1'b0;
      ended_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      released_q     <= released_d;
      score_q        <= score_d;
      lives_q        <= lives_d;
      level_q        <= level_d;
      tick_cnt_q     <= tick_cnt_d;
      spawn_cnt_q    <= spawn_cnt_d;
      column_reset_q <= column_reset_d;
      fall_tick_q    <= fall_tick_d;
      playing_q      <= playing_d;
      ended_q        <= ended_d;
    end
  end

  assign column_reset = column_reset_q;
  assign fall_tick    = fall_tick_q;
  assign score        = score_q;
  assign lives        = lives_q;
  assign level        = level_q;
  assign playing      = playing_q;
  assign ended        = ended_q;

endmodule

// File: tb/tb_flippy_game_controller.sv
// Scoreboard bench for flippy_game_controller: expectations are queued as
// stimulus is driven and compared against the outputs after the clock edge.
module tb_flippy_game_controller;

  localparam int SEL_CR = 0;
  localparam int SEL_FT = 1;
  localparam int SEL_SC = 2;
  localparam int SEL_LV = 3;
  localparam int SEL_LE = 4;
  localparam int SEL_PL = 5;
  localparam int SEL_EN = 6;
  localparam int SEL_PER = 7;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] correct;
  logic [2:0] game_over;
  logic [2:0] column_reset;
  logic       fall_tick;
  logic [7:0] score;
  logic [3:0] lives;
  logic [3:0] level;
  logic       playing;
  logic       ended;

  int n_checks = 0;
  int n_fail   = 0;
  int meas_period = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q[$];

  always #5 clock = ~clock;

  flippy_game_controller #(
    .NUM_COLUMNS(3), .SCORE_WIDTH(8), .LIVES(3), .BASE_PERIOD(10),
    .PERIOD_STEP(2), .MIN_PERIOD(4), .LEVEL_UP_SCORE(4), .SPAWN_GAP(2)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .correct(correct),
    .game_over(game_over), .column_reset(column_reset), .fall_tick(fall_tick),
    .score(score), .lives(lives), .level(level), .playing(playing), .ended(ended)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_obs(input int sel);
    case (sel)
      SEL_CR:  return 32'(column_reset);
      SEL_FT:  return 32'(fall_tick);
      SEL_SC:  return 32'(score);
      SEL_LV:  return 32'(lives);
      SEL_LE:  return 32'(level);
      SEL_PL:  return 32'(playing);
      SEL_EN:  return 32'(ended);
      SEL_PER: return 32'(meas_period);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq(e.tag, get_obs(e.sel), e.val);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse(input logic [2:0] cor, input logic [2:0] go);
    correct   = cor;
    game_over = go;
    step();
    correct   = 3'b000;
    game_over = 3'b000;
  endtask

  task automatic expect_idle(input string tag);
    expect_val({tag, "_cr"}, SEL_CR, 32'd7);
    expect_val({tag, "_ft"}, SEL_FT, 32'd0);
    expect_val({tag, "_score"}, SEL_SC, 32'd0);
    expect_val({tag, "_lives"}, SEL_LV, 32'd3);
    expect_val({tag, "_level"}, SEL_LE, 32'd0);
    expect_val({tag, "_playing"}, SEL_PL, 32'd0);
    expect_val({tag, "_ended"}, SEL_EN, 32'd0);
  endtask

  // Waits for a tick, then counts clocks to the next tick.
  task automatic measure_period();
    int w;
    int timed_out;
    w = 0;
    timed_out = 0;
    while (!fall_tick && w < 100) begin
      step();
      w++;
    end
    if (w >= 100) timed_out = 1;
    meas_period = 0;
    do begin
      step();
      meas_period++;
    end while (!fall_tick && meas_period < 100);
    check_eq("tick_timeout", 32'(timed_out), 32'd0);
  endtask

  initial begin
    int ticks;
    int w;
    reset = 1'b1; start = 1'b0; correct = 3'b000; game_over = 3'b000;
    step(); step();
    reset = 1'b0;
    expect_idle("reset");
    step();
    drain();

    // Start: column 0 released immediately, others staggered by fall ticks.
    expect_val("start_cr", SEL_CR, 32'd6);
    expect_val("start_playing", SEL_PL, 32'd1);
    expect_val("start_ft", SEL_FT, 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    drain();

    for (int i = 1; i <= 40; i++) begin
      correct = (i == 5) ? 3'b100 : 3'b000;
      start   = (i == 7);
      expect_val($sformatf("spawn_ft_%0d", i), SEL_FT, ((i % 10) == 0) ? 32'd1 : 32'd0);
      expect_val($sformatf("spawn_cr_%0d", i), SEL_CR, (i < 20) ? 32'd6 : ((i < 40) ? 32'd4 : 32'd0));
      expect_val($sformatf("spawn_score_%0d", i), SEL_SC, 32'd0);
      step();
      drain();
    end
    correct = 3'b000;
    start   = 1'b0;

    // Two hits in PLAY: score +2, one-cycle respawn pulse on those columns.
    expect_val("hit_score", SEL_SC, 32'd2);
    expect_val("hit_cr", SEL_CR, 32'd5);
    pulse(3'b101, 3'b000);
    drain();
    expect_val("hit_cr_after", SEL_CR, 32'd0);
    expect_val("hit_score_after", SEL_SC, 32'd2);
    step();
    drain();

    // Level and fall-period progression.
    expect_val("lvl1_score", SEL_SC, 32'd4);
    pulse(3'b011, 3'b000);
    drain();
    expect_val("lvl1_level", SEL_LE, 32'd1);
    step();
    drain();
    expect_val("lvl1_period", SEL_PER, 32'd8);
    measure_period();
    drain();

    pulse(3'b111, 3'b000);
    expect_val("lvl2_score", SEL_SC, 32'd8);
    pulse(3'b001, 3'b000);
    drain();
    expect_val("lvl2_level", SEL_LE, 32'd2);
    step();
    drain();
    expect_val("lvl2_period", SEL_PER, 32'd6);
    measure_period();
    drain();

    pulse(3'b111, 3'b000);
    expect_val("lvl3_score", SEL_SC, 32'd12);
    pulse(3'b001, 3'b000);
    drain();
    expect_val("lvl3_level", SEL_LE, 32'd3);
    step();
    drain();
    expect_val("lvl3_period", SEL_PER, 32'd4);
    measure_period();
    drain();

    pulse(3'b111, 3'b000);
    pulse(3'b111, 3'b000);
    expect_val("lvl5_score", SEL_SC, 32'd20);
    pulse(3'b011, 3'b000);
    drain();
    expect_val("lvl5_level", SEL_LE, 32'd5);
    step();
    drain();
    expect_val("lvl5_period", SEL_PER, 32'd4);
    measure_period();
    drain();

    // Correct wins on column 0; columns 1 and 2 miss together.
    expect_val("mix_score", SEL_SC, 32'd21);
    expect_val("mix_lives", SEL_LV, 32'd1);
    expect_val("mix_cr", SEL_CR, 32'd7);
    expect_val("mix_ended", SEL_EN, 32'd0);
    pulse(3'b001, 3'b111);
    drain();

    // Last life lost: game over.
    expect_val("over_lives", SEL_LV, 32'd0);
    expect_val("over_ended", SEL_EN, 32'd1);
    expect_val("over_playing", SEL_PL, 32'd0);
    expect_val("over_cr", SEL_CR, 32'd7);
    expect_val("over_score", SEL_SC, 32'd21);
    pulse(3'b000, 3'b001);
    drain();

    ticks = 0;
    for (int i = 0; i < 30; i++) begin
      correct = (i == 3) ? 3'b111 : 3'b000;
      step();
      if (fall_tick) ticks++;
    end
    correct = 3'b000;
    check_eq("over_ticks", 32'(ticks), 32'd0);
    expect_val("over_score_frozen", SEL_SC, 32'd21);
    expect_val("over_level_frozen", SEL_LE, 32'd5);
    expect_val("over_cr_hold", SEL_CR, 32'd7);
    drain();

    // Restart from OVER clears the game.
    expect_val("restart_score", SEL_SC, 32'd0);
    expect_val("restart_lives", SEL_LV, 32'd3);
    expect_val("restart_playing", SEL_PL, 32'd1);
    expect_val("restart_ended", SEL_EN, 32'd0);
    expect_val("restart_cr", SEL_CR, 32'd6);
    start = 1'b1;
    step();
    start = 1'b0;
    drain();
    expect_val("restart_level", SEL_LE, 32'd0);
    step();
    drain();

    w = 0;
    while (column_reset != 3'b000 && w < 100) begin
      step();
      w++;
    end
    check_eq("play_wait_timeout", (w >= 100) ? 32'd1 : 32'd0, 32'd0);

    // Score saturation.
    for (int i = 0; i < 84; i++) pulse(3'b111, 3'b000);
    expect_val("sat_252", SEL_SC, 32'd252);
    drain();
    expect_val("sat_254", SEL_SC, 32'd254);
    pulse(3'b011, 3'b000);
    drain();
    expect_val("sat_255", SEL_SC, 32'd255);
    pulse(3'b111, 3'b000);
    drain();
    expect_val("sat_hold", SEL_SC, 32'd255);
    pulse(3'b111, 3'b000);
    drain();
    expect_val("sat_level", SEL_LE, 32'd15);
    step();
    drain();
    expect_val("sat_period", SEL_PER, 32'd4);
    measure_period();
    drain();

    // Reset mid-PLAY with events and start pending: IDLE wins, no respawn pulse.
    reset = 1'b1; start = 1'b1; correct = 3'b111; game_over = 3'b010;
    expect_idle("midreset");
    step();
    drain();
    reset = 1'b0; start = 1'b0; correct = 3'b000; game_over = 3'b000;
    expect_idle("post_reset");
    step();
    drain();
    expect_val("post_reset_start_cr", SEL_CR, 32'd6);
    expect_val("post_reset_start_pl", SEL_PL, 32'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
